axi_rd_arbiter: RTL and testbench

- Parametrised N-channel AXI4 read front end for the cache subsystem.
- Generalises the fixed two-port (instruction/data) read path with:
  - configurable channel count and widths;
  - round-robin or fixed priority;
  - a line-granular read-after-write hazard block against the write engine;
  - per-beat error reporting.
- Sits between the icache, dcache and uncached requesters and the AXI AR/R channels.
- One transaction outstanding at a time.

---
 rtl/axi_rd_arbiter_if.sv | 48 ++++
 rtl/axi_rd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Requester, write-hazard and AXI AR/R signals of the N-channel read arbiter.
// The master modport is the arbiter side; slave is the requesters/fabric side.
interface axi_rd_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4
);
    logic [NUM_CH-1:0]        i_req_valid;
    logic [NUM_CH-1:0]        o_req_ready;
    logic [NUM_CH*ADDR_W-1:0] i_req_addr;
    logic [NUM_CH*LEN_W-1:0]  i_req_len;
    logic [NUM_CH*3-1:0]      i_req_size;
    logic [NUM_CH-1:0]        o_resp_valid;
    logic [DATA_W-1:0]        o_resp_data;
    logic                     o_resp_last;
    logic                     o_resp_err;
    logic                     i_wr_busy;
    logic [ADDR_W-1:0]        i_wr_addr;
    logic [ID_W-1:0]          o_arid;
    logic [ADDR_W-1:0]        o_araddr;
    logic [7:0]               o_arlen;
    logic [2:0]               o_arsize;
    logic [1:0]               o_arburst;
    logic                     o_arvalid;
    logic                     i_arready;
    logic [ID_W-1:0]          i_rid;
    logic [DATA_W-1:0]        i_rdata;
    logic [1:0]               i_rresp;
    logic                     i_rlast;
    logic                     i_rvalid;
    logic                     o_rready;

    modport master (
        input  i_req_valid, i_req_addr, i_req_len, i_req_size, i_wr_busy, i_wr_addr,
               i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
        output o_req_ready, o_resp_valid, o_resp_data, o_resp_last, o_resp_err,
               o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_len, i_req_size, i_wr_busy, i_wr_addr,
               i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
        input  o_req_ready, o_resp_valid, o_resp_data, o_resp_last, o_resp_err,
               o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-channel AXI4 read front end: one outstanding burst, round-robin or fixed
// priority, line-granular read-after-write hazard blocking, registered beats.
//   state   | meaning
//   IDLE    | pick an eligible requester, latch its request
//   AR      | present the latched address until accepted
//   R       | forward beats to the granted channel until rlast
module axi_rd_arbiter #(
    parameter int NUM_CH           = 3,
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 32,
    parameter int LEN_W            = 8,
    parameter int ID_W             = 4,
    parameter int LINE_BYTE_OFFSET = 6,
    parameter int PRIO_MODE        = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    axi_rd_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_W = ADDR_W - LINE_BYTE_OFFSET;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic              resp_err_q, resp_err_d;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] req_ready;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;

    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = bus.i_req_valid[c] &&
                !(bus.i_wr_busy &&
                  bus.i_req_addr[c*ADDR_W+LINE_BYTE_OFFSET +: TAG_W] ==
                  bus.i_wr_addr[ADDR_W-1:LINE_BYTE_OFFSET]);
        end
    end

    // First pass searches from the rr pointer upward; second pass covers the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!win_found && eligible[c] && (PRIO_MODE != 0 || IDX_W'(c) >= rr_q)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!win_found && eligible[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready = NUM_CH'(1) << win_idx;
                    grant_d   = win_idx;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (IDX_W'(c) == win_idx) begin
                            addr_d = bus.i_req_addr[c*ADDR_W +: ADDR_W];
                            len_d  = bus.i_req_len[c*LEN_W +: LEN_W];
                            size_d = bus.i_req_size[c*3 +: 3];
                        end
                    end
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (bus.i_arready) state_d = ST_R;
            end
            ST_R: begin
                if (bus.i_rvalid) begin
                    resp_valid_d = NUM_CH'(1) << grant_q;
                    resp_data_d  = bus.i_rdata;
                    resp_last_d  = bus.i_rlast;
                    resp_err_d   = (bus.i_rresp != 2'b00);
                    if (bus.i_rlast) begin
                        state_d = ST_IDLE;
                        if (PRIO_MODE == 0) begin
                            rr_d = (grant_q == IDX_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.o_req_ready  = req_ready;
    assign bus.o_arvalid    = (state_q == ST_AR);
    assign bus.o_araddr     = addr_q;
    assign bus.o_arlen      = 8'(len_q);
    assign bus.o_arsize     = size_q;
    assign bus.o_arid       = ID_W'(grant_q);
    assign bus.o_arburst    = (state_q == ST_AR) ? 2'b01 : 2'b00;
    assign bus.o_rready     = (state_q == ST_R);
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_resp_data  = resp_data_q;
    assign bus.o_resp_last  = resp_last_q;
    assign bus.o_resp_err   = resp_err_q;

    // Single outstanding burst, so the returned ID carries no information.
    logic unused_inputs;
    assign unused_inputs = ^{bus.i_rid, bus.i_wr_addr[LINE_BYTE_OFFSET-1:0]};
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: vector table of arbitration cases plus hand sequences,
// with AR and R-beat scoreboards filled at the handshakes and drained on DUT output.
module tb_axi_rd_arbiter;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int ID_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();
    axi_rd_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) pbus ();

    axi_rd_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                     .ID_W(ID_W), .LINE_BYTE_OFFSET(6), .PRIO_MODE(0))
        dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.master));

    axi_rd_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                     .ID_W(ID_W), .LINE_BYTE_OFFSET(6), .PRIO_MODE(1))
        dut_prio (.i_clk(clk), .i_rst_n(rst_n), .bus(pbus.master));

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic              wr_busy;
        logic [31:0]       wr_addr;
        int                exp_ch;
        int                nbeats;
        int                err_beat;
        int                ar_delay;
        logic [31:0]       base;
    } vec_t;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    beat_t       sb_q[$];
    ar_t         ar_q[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          exp_grant = 0;
    int          active_ch = 0;
    bit          acc_seen = 1'b0;
    bit          drop_on_acc = 1'b1;
    logic [31:0] ch_addr[NUM_CH];
    logic [7:0]  cur_len = 8'd0;
    logic [2:0]  cur_size = 3'd2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic [NUM_CH-1:0] mask);
        bus.i_req_addr  = {ch_addr[2], ch_addr[1], ch_addr[0]};
        bus.i_req_len   = {NUM_CH{cur_len}};
        bus.i_req_size  = {NUM_CH{cur_size}};
        bus.i_req_valid = mask;
    endtask

    // One clock: sample handshakes mid low phase, clock, then compare registered beat.
    task automatic step();
        ar_t   a;
        beat_t b;
        bit    drop_now;
        drop_now = 1'b0;
        #1;
        if (rst_n && |bus.o_req_ready) begin
            check("req_ready_onehot", 64'(bus.o_req_ready), 64'(1) << exp_grant);
            a.id = exp_grant; a.addr = ch_addr[exp_grant]; a.len = cur_len; a.size = cur_size;
            ar_q.push_back(a);
            active_ch = exp_grant;
            acc_seen  = 1'b1;
            drop_now  = drop_on_acc;
        end
        if (rst_n && bus.o_arvalid && bus.i_arready) begin
            if (ar_q.size() == 0) begin
                check("ar_unexpected", 64'(1), 64'(0));
            end else begin
                a = ar_q.pop_front();
                check("arid",    64'(bus.o_arid),    64'(a.id));
                check("araddr",  64'(bus.o_araddr),  64'(a.addr));
                check("arlen",   64'(bus.o_arlen),   64'(a.len));
                check("arsize",  64'(bus.o_arsize),  64'(a.size));
                check("arburst", 64'(bus.o_arburst), 64'(2'b01));
            end
        end
        if (rst_n && bus.i_rvalid && bus.o_rready) begin
            b.ch = active_ch; b.data = bus.i_rdata; b.last = bus.i_rlast; b.err = (bus.i_rresp != 2'b00);
            sb_q.push_back(b);
        end
        @(posedge clk);
        #1;
        if (drop_now) bus.i_req_valid[exp_grant[1:0]] = 1'b0;
        if (!rst_n) begin
            sb_q.delete();
            ar_q.delete();
        end
        @(negedge clk);
        if (sb_q.size() > 0) begin
            b = sb_q.pop_front();
            check("resp_valid", 64'(bus.o_resp_valid), 64'(1) << b.ch);
            check("resp_data",  64'(bus.o_resp_data),  64'(b.data));
            check("resp_last",  64'(bus.o_resp_last),  64'(b.last));
            check("resp_err",   64'(bus.o_resp_err),   64'(b.err));
        end else if (|bus.o_resp_valid) begin
            check("resp_spurious", 64'(bus.o_resp_valid), 64'(0));
        end
    endtask

    task automatic run_txn(input int exp, input int nbeats, input int err_beat, input int ar_delay,
                           input logic [31:0] base, output int wait_steps);
        exp_grant  = exp;
        acc_seen   = 1'b0;
        wait_steps = 0;
        while (!acc_seen && wait_steps < 40) begin
            step();
            wait_steps++;
        end
        if (!acc_seen) begin
            check("accept_timeout", 64'(0), 64'(1));
            return;
        end
        for (int d = 0; d < ar_delay; d++) begin
            check("arvalid_hold", 64'(bus.o_arvalid), 64'(1));
            step();
        end
        check("arvalid", 64'(bus.o_arvalid), 64'(1));
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            check("rready", 64'(bus.o_rready), 64'(1));
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = base + 32'(b);
            bus.i_rlast  = (b == nbeats - 1);
            bus.i_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            step();
            bus.i_rvalid = 1'b0;
            bus.i_rlast  = 1'b0;
            bus.i_rresp  = 2'b00;
            if (b == 0 && nbeats > 2) step();
        end
        check("sb_drained", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic default_addrs();
        ch_addr[0] = 32'h0000_1040;
        ch_addr[1] = 32'h0000_3000;
        ch_addr[2] = 32'h1FC0_0010;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ws;
        int cnt;
        int rr_seq[4];

        vecs[0] = '{3'b100, 1'b0, 32'h0,         2, 1,  -1, 2, 32'hDEAD_BEEF};
        vecs[1] = '{3'b001, 1'b0, 32'h0,         0, 16, -1, 0, 32'h1000_0000};
        vecs[2] = '{3'b111, 1'b0, 32'h0,         1, 2,  -1, 1, 32'h2000_0000};
        vecs[3] = '{3'b011, 1'b0, 32'h0,         0, 2,  -1, 0, 32'h3000_0000};
        vecs[4] = '{3'b101, 1'b0, 32'h0,         2, 4,   2, 0, 32'h4000_0000};
        vecs[5] = '{3'b011, 1'b1, 32'h0000_1050, 1, 1,  -1, 0, 32'h5000_0000};
        vecs[6] = '{3'b110, 1'b0, 32'h0,         2, 1,  -1, 3, 32'h6000_0000};
        vecs[7] = '{3'b010, 1'b0, 32'h0,         1, 3,  -1, 0, 32'h7000_0000};

        default_addrs();
        bus.i_req_valid = '0; bus.i_req_addr = '0; bus.i_req_len = '0; bus.i_req_size = '0;
        bus.i_wr_busy = 1'b0; bus.i_wr_addr = '0; bus.i_arready = 1'b0; bus.i_rid = '0;
        bus.i_rdata = '0; bus.i_rresp = 2'b00; bus.i_rlast = 1'b0; bus.i_rvalid = 1'b0;
        pbus.i_req_valid = 3'b111;
        pbus.i_req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        pbus.i_req_len = '0; pbus.i_req_size = '0; pbus.i_wr_busy = 1'b0; pbus.i_wr_addr = '0;
        pbus.i_arready = 1'b1; pbus.i_rid = '0; pbus.i_rdata = 32'h55; pbus.i_rresp = 2'b00;
        pbus.i_rlast = 1'b1; pbus.i_rvalid = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_arvalid",    64'(bus.o_arvalid),    64'(0));
        check("rst_arburst",    64'(bus.o_arburst),    64'(0));
        check("rst_araddr",     64'(bus.o_araddr),     64'(0));
        check("rst_rready",     64'(bus.o_rready),     64'(0));
        check("rst_resp_valid", 64'(bus.o_resp_valid), 64'(0));
        check("rst_resp_data",  64'(bus.o_resp_data),  64'(0));
        rst_n = 1'b1;

        // Fixed-priority instance with all channels always requesting: channel 0 every time.
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (|pbus.o_req_ready) begin
                check("prio_grant", 64'(pbus.o_req_ready), 64'(3'b001));
                cnt++;
            end
            @(negedge clk);
        end
        check("prio_grant_count", 64'(cnt), 64'(5));

        for (int i = 0; i < 8; i++) begin
            default_addrs();
            cur_len       = 8'(vecs[i].nbeats - 1);
            cur_size      = 3'd2;
            drop_on_acc   = 1'b1;
            bus.i_wr_busy = vecs[i].wr_busy;
            bus.i_wr_addr = vecs[i].wr_addr;
            drive_req(vecs[i].mask);
            run_txn(vecs[i].exp_ch, vecs[i].nbeats, vecs[i].err_beat, vecs[i].ar_delay, vecs[i].base, ws);
            check("accept_latency", 64'(ws), 64'(1));
            bus.i_req_valid = '0;
            bus.i_wr_busy   = 1'b0;
        end

        // Hazard: ch0 shares the written line, ch1 goes first, ch0 waits for the write.
        ch_addr[0] = 32'h0000_2030;
        ch_addr[1] = 32'h0000_3000;
        cur_len = 8'd0;
        bus.i_wr_busy = 1'b1;
        bus.i_wr_addr = 32'h0000_2008;
        drive_req(3'b011);
        run_txn(1, 1, -1, 0, 32'h8000_0000, ws);
        exp_grant = 0;
        acc_seen  = 1'b0;
        repeat (3) step();
        check("hazard_stall", 64'(acc_seen), 64'(0));
        bus.i_wr_busy = 1'b0;
        run_txn(0, 1, -1, 1, 32'h8100_0000, ws);
        check("hazard_release_latency", 64'(ws), 64'(1));
        bus.i_req_valid = '0;

        // Reset during beat 5 of a 16-beat refill.
        default_addrs();
        cur_len = 8'd15;
        drive_req(3'b001);
        exp_grant = 0;
        acc_seen  = 1'b0;
        ws = 0;
        while (!acc_seen && ws < 40) begin
            step();
            ws++;
        end
        check("rst_seq_accept", 64'(acc_seen), 64'(1));
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = 32'h9000_0000 + 32'(b);
            step();
        end
        bus.i_rdata = 32'h9000_0004;
        rst_n = 1'b0;
        step();
        bus.i_rvalid = 1'b0;
        check("midrst_req_ready",  64'(bus.o_req_ready),  64'(0));
        check("midrst_resp_valid", 64'(bus.o_resp_valid), 64'(0));
        check("midrst_resp_data",  64'(bus.o_resp_data),  64'(0));
        check("midrst_resp_last",  64'(bus.o_resp_last),  64'(0));
        check("midrst_resp_err",   64'(bus.o_resp_err),   64'(0));
        check("midrst_arvalid",    64'(bus.o_arvalid),    64'(0));
        check("midrst_arid",       64'(bus.o_arid),       64'(0));
        check("midrst_araddr",     64'(bus.o_araddr),     64'(0));
        check("midrst_arlen",      64'(bus.o_arlen),      64'(0));
        check("midrst_arsize",     64'(bus.o_arsize),     64'(0));
        check("midrst_arburst",    64'(bus.o_arburst),    64'(0));
        check("midrst_rready",     64'(bus.o_rready),     64'(0));
        rst_n = 1'b1;

        // All channels held valid from a fresh rr pointer: 0,1,2,0, back to back.
        rr_seq = '{0, 1, 2, 0};
        cur_len = 8'd1;
        drop_on_acc = 1'b0;
        drive_req(3'b111);
        for (int k = 0; k < 4; k++) begin
            run_txn(rr_seq[k], 2, -1, 0, 32'hA000_0000 + 32'(k * 16), ws);
            if (k > 0) check("rr_back_to_back", 64'(ws), 64'(1));
        end
        bus.i_req_valid = '0;
        drop_on_acc = 1'b1;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
